// File: rtl/typed_stream_arbiter.sv
// typed_stream_arbiter: packet-level round-robin arbiter that shares one
// NDataToAXITyped adapter between N_REQ typed ndata requesters. A grant is
// held for a whole packet, and the granted requester's element width is
// latched for that packet so the adapter's 32-bit pairing state stays
// consistent across beats.
//
// Optional build macro TYPED_STREAM_ARBITER_STATS_EN adds per-requester
// completed-packet counters (pkt_count) with a synchronous clear (stats_clear).

package typed_stream_arbiter_pkg;
    typedef enum logic [0:0] {
        BIT32 = 1'b0,
        BIT64 = 1'b1
    } type_width_t;
endpackage

module typed_stream_arbiter
    import typed_stream_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int NUM_ELEMENTS = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [N_REQ-1:0]                         req_enable,
    input  type_width_t [N_REQ-1:0]                  in_type_width,
    input  logic [N_REQ-1:0][NUM_ELEMENTS-1:0][63:0] in_data,
    input  logic [N_REQ-1:0][NUM_ELEMENTS-1:0]       in_keep,
    input  logic [N_REQ-1:0]                         in_last,
    input  logic [N_REQ-1:0]                         in_valid,
    output logic [N_REQ-1:0]                         in_ready,
    output type_width_t                              out_type_width,
    output logic [NUM_ELEMENTS-1:0][63:0]            out_data,
    output logic [NUM_ELEMENTS-1:0]                  out_keep,
    output logic                                     out_last,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [$clog2(N_REQ)-1:0]                 grant_idx,
    output logic                                     busy
`ifdef TYPED_STREAM_ARBITER_STATS_EN
    ,
    input  logic                                     stats_clear,
    output logic [N_REQ-1:0][31:0]                   pkt_count
`endif
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [IW-1:0]     rr_ptr_r;
    logic [IW-1:0]     grant_idx_r;
    type_width_t       type_width_r;
    logic [N_REQ-1:0]  eligible_s;
    logic [IW-1:0]     pick_s;
    logic              any_eligible_s;
    logic              fire_s;
    logic [IW-1:0]     grant_next_s;

    assign eligible_s     = in_valid & req_enable;
    assign fire_s         = (state_r == BURST) && out_valid && out_ready && out_last;
    assign grant_next_s   = (grant_idx_r == IW'(N_REQ - 1)) ? '0 : grant_idx_r + IW'(1);
    assign grant_idx      = grant_idx_r;
    assign out_type_width = type_width_r;
    assign busy           = (state_r == BURST);

    // Round-robin search: first eligible index starting at rr_ptr, wrapping.
    always_comb begin : pick_comb
        int idx_v;
        idx_v          = 0;
        pick_s         = '0;
        any_eligible_s = 1'b0;
        // Walk downwards so the offset closest to rr_ptr is written last and wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_v = int'(rr_ptr_r) + k;
            if (idx_v >= N_REQ) begin
                idx_v = idx_v - N_REQ;
            end else begin
                idx_v = idx_v;
            end
            if (eligible_s[idx_v]) begin
                pick_s         = idx_v[IW-1:0];
                any_eligible_s = 1'b1;
            end else begin
                pick_s         = pick_s;
            end
        end
    end

    // Next-state logic: IDLE arbitrates (one bubble), BURST runs until last handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_eligible_s) begin
                    state_nxt_s = BURST;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                if (fire_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BURST;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath mux: only the granted requester is visible and only during BURST.
    always_comb begin
        out_data  = '0;
        out_keep  = '0;
        out_last  = 1'b0;
        out_valid = 1'b0;
        in_ready  = '0;
        if (state_r == BURST) begin
            out_data              = in_data[grant_idx_r];
            out_keep              = in_keep[grant_idx_r];
            out_last              = in_last[grant_idx_r];
            out_valid             = in_valid[grant_idx_r];
            in_ready[grant_idx_r] = out_ready;
        end else begin
            in_ready = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant, width latch and round-robin pointer; width is frozen for the whole packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r     <= '0;
            grant_idx_r  <= '0;
            type_width_r <= BIT64;
        end else if ((state_r == IDLE) && any_eligible_s) begin
            grant_idx_r  <= pick_s;
            type_width_r <= in_type_width[pick_s];
        end else if (fire_s) begin
            rr_ptr_r     <= grant_next_s;
        end else begin
            rr_ptr_r     <= rr_ptr_r;
        end
    end

`ifdef TYPED_STREAM_ARBITER_STATS_EN
    logic [N_REQ-1:0][31:0] pkt_count_r;

    assign pkt_count = pkt_count_r;

    // Completed-packet counters; a clear in the same cycle as a completion wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_r <= '0;
        end else if (stats_clear) begin
            pkt_count_r <= '0;
        end else if (fire_s) begin
            pkt_count_r[grant_idx_r] <= pkt_count_r[grant_idx_r] + 32'd1;
        end else begin
            pkt_count_r <= pkt_count_r;
        end
    end
`endif

endmodule

// File: tb/tb_typed_stream_arbiter.sv
// Directed self-checking bench for typed_stream_arbiter (N_REQ=4, NUM_ELEMENTS=8).
// Each requester is a small producer that emits packets of plen beats with a
// recognisable data pattern; expected grants, timing and widths are fixed by hand.
module tb_typed_stream_arbiter;
    import typed_stream_arbiter_pkg::*;

    logic                      clk;
    logic                      rst_n;
    logic [3:0]                req_enable;
    type_width_t [3:0]         in_type_width;
    logic [3:0][7:0][63:0]     in_data;
    logic [3:0][7:0]           in_keep;
    logic [3:0]                in_last;
    logic [3:0]                in_valid;
    logic [3:0]                in_ready;
    type_width_t               out_type_width;
    logic [7:0][63:0]          out_data;
    logic [7:0]                out_keep;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [1:0]                grant_idx;
    logic                      busy;
`ifdef TYPED_STREAM_ARBITER_STATS_EN
    logic                      stats_clear;
    logic [3:0][31:0]          pkt_count;
`endif

    typed_stream_arbiter #(.N_REQ(4), .NUM_ELEMENTS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_enable     (req_enable),
        .in_type_width  (in_type_width),
        .in_data        (in_data),
        .in_keep        (in_keep),
        .in_last        (in_last),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_type_width (out_type_width),
        .out_data       (out_data),
        .out_keep       (out_keep),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .grant_idx      (grant_idx),
        .busy           (busy)
`ifdef TYPED_STREAM_ARBITER_STATS_EN
        ,
        .stats_clear    (stats_clear),
        .pkt_count      (pkt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int inv_bad = 0;

    // producer model
    int          plen [4];
    int          beat_cnt [4];
    int          pkt_cnt [4];
    int          pkt_limit [4];
    logic [3:0]  valid_en;
    type_width_t tw [4];

    // observations taken just before the active edge of each cycle
    logic             obs_valid;
    logic             obs_last;
    logic             obs_fire;
    logic             obs_hs;
    logic             obs_busy;
    logic [1:0]       obs_grant;
    type_width_t      obs_tw;
    logic [7:0][63:0] obs_data;
    logic [7:0]       obs_keep;

    function automatic logic [7:0][63:0] exp_beat(input int i, input int p, input int b);
        logic [7:0][63:0] v;
        for (int e = 0; e < 8; e++) begin
            v[e] = {8'(i), 8'(p), 8'(b), 8'(e), 32'hC0DE_0000};
        end
        return v;
    endfunction

    task automatic init_model();
        for (int i = 0; i < 4; i++) begin
            plen[i]      = 1;
            beat_cnt[i]  = 0;
            pkt_cnt[i]   = 0;
            pkt_limit[i] = 1000;
            tw[i]        = BIT64;
        end
        valid_en   = 4'b0000;
        req_enable = 4'b0000;
        out_ready  = 1'b1;
`ifdef TYPED_STREAM_ARBITER_STATS_EN
        stats_clear = 1'b0;
`endif
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            in_valid[i]      = valid_en[i] && (pkt_cnt[i] < pkt_limit[i]);
            in_last[i]       = (beat_cnt[i] == plen[i] - 1);
            in_data[i]       = exp_beat(i, pkt_cnt[i], beat_cnt[i]);
            in_keep[i]       = 8'(i * 16 + beat_cnt[i]);
            in_type_width[i] = tw[i];
        end
    endtask

    // one clock: drive, sample before the edge, clock, advance producers that handshook
    task automatic cycle();
        logic [3:0] hs;
        drive_inputs();
        #1;
        obs_valid = out_valid;
        obs_last  = out_last;
        obs_hs    = out_valid && out_ready;
        obs_fire  = out_valid && out_ready && out_last;
        obs_busy  = busy;
        obs_grant = grant_idx;
        obs_tw    = out_type_width;
        obs_data  = out_data;
        obs_keep  = out_keep;
        hs        = in_valid & in_ready;
        if (($countones(in_ready) > 1) || (!busy && (in_ready != 4'b0000))) begin
            inv_bad++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                if (beat_cnt[i] == plen[i] - 1) begin
                    beat_cnt[i] = 0;
                    pkt_cnt[i]++;
                end else begin
                    beat_cnt[i]++;
                end
            end
        end
    endtask

    task automatic do_reset();
        init_model();
        rst_n = 1'b0;
        drive_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        init_model();
        valid_en   = 4'b1111;
        req_enable = 4'b1111;
        rst_n      = 1'b0;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d want 0", grant_idx); end
        checks++; if (out_type_width !== BIT64) begin errors++; $display("FAIL rst_type_width got %b want 1", out_type_width); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready got %b want 0000", in_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if ((out_valid !== 1'b0) || (in_ready !== 4'b0000)) begin errors++; $display("FAIL rst_release got valid=%b ready=%b want 0/0000", out_valid, in_ready); end
    endtask

    task automatic test_fairness();
        int fg[$];
        int fc[$];
        int want_g[5] = '{0, 1, 2, 3, 0};
        int want_c[5] = '{2, 5, 8, 11, 14};
        do_reset();
        valid_en   = 4'b1111;
        req_enable = 4'b1111;
        for (int i = 0; i < 4; i++) plen[i] = 2;
        for (int c = 0; c < 15; c++) begin
            cycle();
            if (c == 0) begin
                checks++; if ((obs_valid !== 1'b0) || (obs_busy !== 1'b0)) begin errors++; $display("FAIL fair_bubble got valid=%b busy=%b want 0/0", obs_valid, obs_busy); end
            end
            if (c == 1) begin
                checks++; if (obs_data !== exp_beat(0, 0, 0)) begin errors++; $display("FAIL fair_data_c1 got %h want %h", obs_data[0], exp_beat(0, 0, 0) >> 0); end
            end
            if (c == 4) begin
                checks++; if (obs_keep !== 8'h10) begin errors++; $display("FAIL fair_keep_c4 got %h want 10", obs_keep); end
            end
            if (c == 13) begin
                checks++; if (obs_data !== exp_beat(0, 1, 0)) begin errors++; $display("FAIL fair_data_c13 got %h want second packet of req0", obs_data[0]); end
            end
            if (obs_fire) begin
                fg.push_back(int'(obs_grant));
                fc.push_back(c);
            end
        end
        checks++; if (fg.size() !== 5) begin errors++; $display("FAIL fair_npkts got %0d want 5", fg.size()); end
        for (int k = 0; k < 5; k++) begin
            if (k < fg.size()) begin
                checks++; if (fg[k] !== want_g[k]) begin errors++; $display("FAIL fair_grant%0d got %0d want %0d", k, fg[k], want_g[k]); end
                checks++; if (fc[k] !== want_c[k]) begin errors++; $display("FAIL fair_cycle%0d got %0d want %0d", k, fc[k], want_c[k]); end
            end
        end
    endtask

    task automatic test_width_lock();
        do_reset();
        valid_en   = 4'b0010;
        req_enable = 4'b0010;
        plen[1]    = 4;
        tw[1]      = BIT32;
        for (int c = 0; c < 7; c++) begin
            if (c == 2) tw[1] = BIT64;
            cycle();
            if ((c >= 1) && (c <= 4)) begin
                checks++; if (obs_tw !== BIT32) begin errors++; $display("FAIL lock_tw_c%0d got %b want 0", c, obs_tw); end
            end
            if (c == 4) begin
                checks++; if (obs_fire !== 1'b1) begin errors++; $display("FAIL lock_last_c4 got %b want 1", obs_fire); end
            end
            if (c == 6) begin
                checks++; if ((obs_tw !== BIT64) || (obs_grant !== 2'd1)) begin errors++; $display("FAIL lock_relatch got tw=%b grant=%0d want 1/1", obs_tw, obs_grant); end
            end
        end
    endtask

    task automatic test_mask_backpressure();
        int fg[$];
        int fb[$];
        int beats;
        int want_g[3] = '{1, 3, 1};
        do_reset();
        valid_en   = 4'b1111;
        req_enable = 4'b1010;
        for (int i = 0; i < 4; i++) plen[i] = 3;
        beats = 0;
        for (int c = 0; c < 15; c++) begin
            out_ready = !((c >= 2) && (c <= 4));
            cycle();
            if ((c >= 2) && (c <= 4)) begin
                checks++; if ((obs_valid !== 1'b1) || (obs_data !== exp_beat(1, 0, 1))) begin errors++; $display("FAIL bp_hold_c%0d got valid=%b elem0=%h want 1/%h", c, obs_valid, obs_data[0], {8'd1, 8'd0, 8'd1, 8'd0, 32'hC0DE_0000}); end
            end
            if (obs_hs) beats++;
            if (obs_fire) begin
                fg.push_back(int'(obs_grant));
                fb.push_back(beats);
                beats = 0;
            end
        end
        out_ready = 1'b1;
        checks++; if (fg.size() !== 3) begin errors++; $display("FAIL mask_npkts got %0d want 3", fg.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < fg.size()) begin
                checks++; if (fg[k] !== want_g[k]) begin errors++; $display("FAIL mask_grant%0d got %0d want %0d", k, fg[k], want_g[k]); end
                checks++; if (fb[k] !== 3) begin errors++; $display("FAIL bp_beats%0d got %0d want 3", k, fb[k]); end
            end
        end
    endtask

    task automatic test_disable_stall();
        do_reset();
        valid_en   = 4'b1111;
        req_enable = 4'b0101;
        for (int i = 0; i < 4; i++) plen[i] = 2;
        for (int c = 0; c < 13; c++) begin
            if (c == 5) req_enable[2] = 1'b0;
            valid_en[2] = !((c == 5) || (c == 6));
            cycle();
            if (c == 4) begin
                checks++; if (obs_grant !== 2'd2) begin errors++; $display("FAIL dis_grant_c4 got %0d want 2", obs_grant); end
            end
            if ((c == 5) || (c == 6)) begin
                checks++; if ((obs_valid !== 1'b0) || (obs_busy !== 1'b1) || (obs_grant !== 2'd2)) begin errors++; $display("FAIL stall_c%0d got valid=%b busy=%b grant=%0d want 0/1/2", c, obs_valid, obs_busy, obs_grant); end
            end
            if (c == 7) begin
                checks++; if ((obs_fire !== 1'b1) || (obs_grant !== 2'd2)) begin errors++; $display("FAIL dis_complete got fire=%b grant=%0d want 1/2", obs_fire, obs_grant); end
            end
            if ((c == 9) || (c == 12)) begin
                checks++; if ((obs_grant !== 2'd0) || (obs_busy !== 1'b1)) begin errors++; $display("FAIL dis_skip_c%0d got grant=%0d busy=%b want 0/1", c, obs_grant, obs_busy); end
            end
        end
    endtask

    task automatic test_single_beat_wrap();
        do_reset();
        valid_en   = 4'b1111;
        req_enable = 4'b1001;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (c == 1) begin
                checks++; if ((obs_fire !== 1'b1) || (obs_grant !== 2'd0)) begin errors++; $display("FAIL single_c1 got fire=%b grant=%0d want 1/0", obs_fire, obs_grant); end
            end
            if (c == 2) begin
                checks++; if ((obs_valid !== 1'b0) || (obs_busy !== 1'b0)) begin errors++; $display("FAIL single_idle got valid=%b busy=%b want 0/0", obs_valid, obs_busy); end
            end
            if (c == 3) begin
                checks++; if ((obs_fire !== 1'b1) || (obs_grant !== 2'd3)) begin errors++; $display("FAIL single_c3 got fire=%b grant=%0d want 1/3", obs_fire, obs_grant); end
            end
            if (c == 5) begin
                checks++; if ((obs_grant !== 2'd0) || (obs_busy !== 1'b1)) begin errors++; $display("FAIL wrap_c5 got grant=%0d busy=%b want 0/1", obs_grant, obs_busy); end
            end
        end
    endtask

`ifdef TYPED_STREAM_ARBITER_STATS_EN
    task automatic test_stats();
        do_reset();
        valid_en     = 4'b1001;
        req_enable   = 4'b1001;
        pkt_limit[0] = 5;
        pkt_limit[3] = 3;
        for (int c = 0; c < 20; c++) cycle();
        checks++; if (pkt_count[0] !== 32'd5) begin errors++; $display("FAIL stats_req0 got %0d want 5", pkt_count[0]); end
        checks++; if (pkt_count[3] !== 32'd3) begin errors++; $display("FAIL stats_req3 got %0d want 3", pkt_count[3]); end
        checks++; if (pkt_count[1] !== 32'd0) begin errors++; $display("FAIL stats_req1 got %0d want 0", pkt_count[1]); end
        pkt_limit[0] = 7;
        cycle();
        stats_clear = 1'b1;
        cycle();
        stats_clear = 1'b0;
        checks++; if (obs_fire !== 1'b1) begin errors++; $display("FAIL stats_clr_fire got %b want 1", obs_fire); end
        checks++; if ((pkt_count[0] !== 32'd0) || (pkt_count[3] !== 32'd0)) begin errors++; $display("FAIL stats_clear got %0d/%0d want 0/0", pkt_count[0], pkt_count[3]); end
        cycle();
        cycle();
        checks++; if (pkt_count[0] !== 32'd1) begin errors++; $display("FAIL stats_after_clear got %0d want 1", pkt_count[0]); end
    endtask
`endif

    task automatic test_invariants();
        checks++; if (inv_bad !== 0) begin errors++; $display("FAIL in_ready_onehot got %0d bad cycles want 0", inv_bad); end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_width_lock();
        test_mask_backpressure();
        test_disable_stall();
        test_single_beat_wrap();
`ifdef TYPED_STREAM_ARBITER_STATS_EN
        test_stats();
`endif
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
